alu_rs: RTL and testbench

Reservation station for the integer ALU path. Buffers decoded arithmetic, logic and compare instructions until both source operands are available. Captures operand values broadcast on the ALU and load/store result buses, and issues at most one ready instruction per cycle to the ALU. Sits between the decoder/dispatch stage (upstream) and the ALU (downstream); the registered issue outputs drive the ALU inputs directly.

---
 rtl/alu_rs_if.sv | 66 ++++++
 rtl/alu_rs.sv | 167 ++++++++++++++++
 tb/tb_alu_rs.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// ---------------------------------------------------------------------------
// alu_rs_if : dispatch, CDB snoop and ALU issue bundle for the ALU reservation
//             station.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CALC_OP_L1_NUM_WIDTH
`define CALC_OP_L1_NUM_WIDTH 3
`endif

interface alu_rs_if #(
    parameter int ROB_W = `ROB_SIZE_WIDTH,
    parameter int OP_W  = `CALC_OP_L1_NUM_WIDTH
);
    logic               rdy_in;
    logic               need_flush_in;
    logic               dispatch_valid_in;
    logic [OP_W-1:0]    dispatch_op_L1_in;
    logic               dispatch_op_L2_in;
    logic [31:0]        dispatch_vj_in;
    logic [31:0]        dispatch_vk_in;
    logic [ROB_W:0]     dispatch_qj_in;
    logic [ROB_W:0]     dispatch_qk_in;
    logic [ROB_W:0]     dispatch_rob_in;
    logic               full_out;
    logic               alu_cdb_ready_in;
    logic [31:0]        alu_cdb_value_in;
    logic [ROB_W:0]     alu_cdb_dep_in;
    logic               lsb_cdb_ready_in;
    logic [31:0]        lsb_cdb_value_in;
    logic [ROB_W:0]     lsb_cdb_dep_in;
    logic               valid_out;
    logic [31:0]        opr1_out;
    logic [31:0]        opr2_out;
    logic [ROB_W:0]     dependency_out;
    logic [OP_W-1:0]    alu_op_L1_out;
    logic               alu_op_L2_out;

    modport slave (
        input  rdy_in, need_flush_in,
        input  dispatch_valid_in, dispatch_op_L1_in, dispatch_op_L2_in,
        input  dispatch_vj_in, dispatch_vk_in, dispatch_qj_in, dispatch_qk_in,
        input  dispatch_rob_in,
        input  alu_cdb_ready_in, alu_cdb_value_in, alu_cdb_dep_in,
        input  lsb_cdb_ready_in, lsb_cdb_value_in, lsb_cdb_dep_in,
        output full_out, valid_out, opr1_out, opr2_out, dependency_out,
        output alu_op_L1_out, alu_op_L2_out
    );

    modport master (
        output rdy_in, need_flush_in,
        output dispatch_valid_in, dispatch_op_L1_in, dispatch_op_L2_in,
        output dispatch_vj_in, dispatch_vk_in, dispatch_qj_in, dispatch_qk_in,
        output dispatch_rob_in,
        output alu_cdb_ready_in, alu_cdb_value_in, alu_cdb_dep_in,
        output lsb_cdb_ready_in, lsb_cdb_value_in, lsb_cdb_dep_in,
        input  full_out, valid_out, opr1_out, opr2_out, dependency_out,
        input  alu_op_L1_out, alu_op_L2_out
    );
endinterface

`default_nettype wire

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs : integer ALU reservation station; holds instructions until both
//          operands arrive, snoops ALU/LSB result buses, issues one per cycle.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CALC_OP_L1_NUM_WIDTH
`define CALC_OP_L1_NUM_WIDTH 3
`endif

module alu_rs #(
    parameter int RS_SIZE_WIDTH = 3,
    parameter int ROB_W         = `ROB_SIZE_WIDTH,
    parameter int OP_W          = `CALC_OP_L1_NUM_WIDTH
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    alu_rs_if.slave   bus
);
    localparam int                c_ENTRIES = 1 << RS_SIZE_WIDTH;
    localparam int                c_TAG_W   = ROB_W + 1;
    localparam int                c_QV_W    = c_TAG_W + 32;
    localparam logic [c_TAG_W-1:0] c_NO_TAG = '1;

    logic [c_ENTRIES-1:0]     r_busy;
    logic [OP_W-1:0]          r_op1 [c_ENTRIES];
    logic                     r_op2 [c_ENTRIES];
    logic [31:0]              r_vj  [c_ENTRIES];
    logic [31:0]              r_vk  [c_ENTRIES];
    logic [c_TAG_W-1:0]       r_qj  [c_ENTRIES];
    logic [c_TAG_W-1:0]       r_qk  [c_ENTRIES];
    logic [c_TAG_W-1:0]       r_rob [c_ENTRIES];

    logic                     r_valid;
    logic [31:0]              r_opr1;
    logic [31:0]              r_opr2;
    logic [c_TAG_W-1:0]       r_dep;
    logic [OP_W-1:0]          r_alu_op1;
    logic                     r_alu_op2;

    logic [c_ENTRIES-1:0]     w_ready;
    logic                     w_iss_found;
    logic [RS_SIZE_WIDTH-1:0] w_iss_idx;
    logic                     w_free_found;
    logic [RS_SIZE_WIDTH-1:0] w_free_idx;
    logic                     w_full;
    logic [c_QV_W-1:0]        w_j_nx [c_ENTRIES];
    logic [c_QV_W-1:0]        w_k_nx [c_ENTRIES];
    logic [c_QV_W-1:0]        w_dj;
    logic [c_QV_W-1:0]        w_dk;

    // Returns {tag, value} after snooping both buses; ALU bus takes precedence.
    function automatic logic [c_QV_W-1:0] f_snoop(
        input logic [c_TAG_W-1:0] q,
        input logic [31:0]        v,
        input logic               a_rdy,
        input logic [c_TAG_W-1:0] a_tag,
        input logic [31:0]        a_val,
        input logic               l_rdy,
        input logic [c_TAG_W-1:0] l_tag,
        input logic [31:0]        l_val
    );
        logic [c_QV_W-1:0] res;
        res = {q, v};
        if (q != c_NO_TAG) begin
            if (a_rdy && (q == a_tag))
                res = {c_NO_TAG, a_val};
            else if (l_rdy && (q == l_tag))
                res = {c_NO_TAG, l_val};
        end
        return res;
    endfunction

    always_comb begin
        w_ready      = '0;
        w_iss_found  = 1'b0;
        w_iss_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            w_ready[i] = r_busy[i] && (r_qj[i] == c_NO_TAG) && (r_qk[i] == c_NO_TAG);
            w_j_nx[i]  = f_snoop(r_qj[i], r_vj[i],
                                 bus.alu_cdb_ready_in, bus.alu_cdb_dep_in, bus.alu_cdb_value_in,
                                 bus.lsb_cdb_ready_in, bus.lsb_cdb_dep_in, bus.lsb_cdb_value_in);
            w_k_nx[i]  = f_snoop(r_qk[i], r_vk[i],
                                 bus.alu_cdb_ready_in, bus.alu_cdb_dep_in, bus.alu_cdb_value_in,
                                 bus.lsb_cdb_ready_in, bus.lsb_cdb_dep_in, bus.lsb_cdb_value_in);
        end
        // Scan downward so the lowest index is the last one written.
        for (int i = c_ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_iss_found = 1'b1;
                w_iss_idx   = RS_SIZE_WIDTH'(i);
            end
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_SIZE_WIDTH'(i);
            end
        end
        w_full = ~w_free_found;
        w_dj   = f_snoop(bus.dispatch_qj_in, bus.dispatch_vj_in,
                         bus.alu_cdb_ready_in, bus.alu_cdb_dep_in, bus.alu_cdb_value_in,
                         bus.lsb_cdb_ready_in, bus.lsb_cdb_dep_in, bus.lsb_cdb_value_in);
        w_dk   = f_snoop(bus.dispatch_qk_in, bus.dispatch_vk_in,
                         bus.alu_cdb_ready_in, bus.alu_cdb_dep_in, bus.alu_cdb_value_in,
                         bus.lsb_cdb_ready_in, bus.lsb_cdb_dep_in, bus.lsb_cdb_value_in);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy    <= '0;
            r_valid   <= 1'b0;
            r_opr1    <= '0;
            r_opr2    <= '0;
            r_dep     <= c_NO_TAG;
            r_alu_op1 <= '0;
            r_alu_op2 <= 1'b0;
        end else if (bus.rdy_in) begin
            if (bus.need_flush_in) begin
                r_busy  <= '0;
                r_valid <= 1'b0;
            end else begin
                for (int i = 0; i < c_ENTRIES; i++) begin
                    if (r_busy[i]) begin
                        {r_qj[i], r_vj[i]} <= w_j_nx[i];
                        {r_qk[i], r_vk[i]} <= w_k_nx[i];
                    end
                end
                if (w_iss_found) begin
                    r_valid           <= 1'b1;
                    r_opr1            <= r_vj[w_iss_idx];
                    r_opr2            <= r_vk[w_iss_idx];
                    r_dep             <= r_rob[w_iss_idx];
                    r_alu_op1         <= r_op1[w_iss_idx];
                    r_alu_op2         <= r_op2[w_iss_idx];
                    r_busy[w_iss_idx] <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                end
                // The chosen free entry was idle at cycle start, so it never collides with issue.
                if (bus.dispatch_valid_in && !w_full) begin
                    r_busy[w_free_idx]                 <= 1'b1;
                    r_op1[w_free_idx]                  <= bus.dispatch_op_L1_in;
                    r_op2[w_free_idx]                  <= bus.dispatch_op_L2_in;
                    r_rob[w_free_idx]                  <= bus.dispatch_rob_in;
                    {r_qj[w_free_idx], r_vj[w_free_idx]} <= w_dj;
                    {r_qk[w_free_idx], r_vk[w_free_idx]} <= w_dk;
                end
            end
        end
    end

    assign bus.full_out       = w_full;
    assign bus.valid_out      = r_valid;
    assign bus.opr1_out       = r_opr1;
    assign bus.opr2_out       = r_opr2;
    assign bus.dependency_out = r_dep;
    assign bus.alu_op_L1_out  = r_alu_op1;
    assign bus.alu_op_L2_out  = r_alu_op2;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs : directed self-checking bench for the ALU reservation station.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_rs;
    localparam logic [4:0] c_NO = 5'h1F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_rs_if #(.ROB_W(4), .OP_W(3)) bus ();

    alu_rs #(.RS_SIZE_WIDTH(3), .ROB_W(4), .OP_W(3)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.need_flush_in     = 1'b0;
        bus.dispatch_valid_in = 1'b0;
        bus.dispatch_op_L1_in = '0;
        bus.dispatch_op_L2_in = 1'b0;
        bus.dispatch_vj_in    = '0;
        bus.dispatch_vk_in    = '0;
        bus.dispatch_qj_in    = c_NO;
        bus.dispatch_qk_in    = c_NO;
        bus.dispatch_rob_in   = '0;
        bus.alu_cdb_ready_in  = 1'b0;
        bus.alu_cdb_value_in  = '0;
        bus.alu_cdb_dep_in    = '0;
        bus.lsb_cdb_ready_in  = 1'b0;
        bus.lsb_cdb_value_in  = '0;
        bus.lsb_cdb_dep_in    = '0;
    endtask

    task automatic disp(input logic [2:0] op1, input logic op2,
                        input logic [31:0] vj, input logic [4:0] qj,
                        input logic [31:0] vk, input logic [4:0] qk,
                        input logic [4:0] rob);
        bus.dispatch_valid_in = 1'b1;
        bus.dispatch_op_L1_in = op1;
        bus.dispatch_op_L2_in = op2;
        bus.dispatch_vj_in    = vj;
        bus.dispatch_qj_in    = qj;
        bus.dispatch_vk_in    = vk;
        bus.dispatch_qk_in    = qk;
        bus.dispatch_rob_in   = rob;
    endtask

    initial begin
        idle();
        bus.rdy_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_dep", bus.dependency_out, c_NO);
        chk("rst_full", bus.full_out, 0);
        chk("rst_opr1", bus.opr1_out, 0);
        chk("rst_op1", bus.alu_op_L1_out, 0);

        // ADD with both operands ready
        disp(3'd0, 1'b0, 32'd5, c_NO, 32'd7, c_NO, 5'd2);
        tick();
        idle();
        chk("add_not_yet", bus.valid_out, 0);
        tick();
        chk("add_valid", bus.valid_out, 1);
        chk("add_opr1", bus.opr1_out, 5);
        chk("add_opr2", bus.opr2_out, 7);
        chk("add_dep", bus.dependency_out, 2);
        chk("add_op1", bus.alu_op_L1_out, 0);
        chk("add_op2", bus.alu_op_L2_out, 0);
        tick();
        chk("add_pulse_end", bus.valid_out, 0);
        chk("add_hold_opr1", bus.opr1_out, 5);

        // SUB waiting on tag 4, woken by ALU bus
        disp(3'd0, 1'b1, 32'd0, 5'd4, 32'd1, c_NO, 5'd3);
        tick();
        idle();
        tick();
        chk("sub_wait", bus.valid_out, 0);
        bus.alu_cdb_ready_in = 1'b1;
        bus.alu_cdb_dep_in   = 5'd4;
        bus.alu_cdb_value_in = 32'd10;
        tick();
        idle();
        chk("sub_wake_edge", bus.valid_out, 0);
        tick();
        chk("sub_valid", bus.valid_out, 1);
        chk("sub_opr1", bus.opr1_out, 10);
        chk("sub_opr2", bus.opr2_out, 1);
        chk("sub_op2", bus.alu_op_L2_out, 1);
        chk("sub_dep", bus.dependency_out, 3);

        // Forwarding from LSB bus during dispatch
        disp(3'd3, 1'b0, 32'd9, c_NO, 32'd0, 5'd6, 5'd5);
        bus.lsb_cdb_ready_in = 1'b1;
        bus.lsb_cdb_dep_in   = 5'd6;
        bus.lsb_cdb_value_in = 32'h8000_0000;
        tick();
        idle();
        chk("fwd_edge", bus.valid_out, 0);
        tick();
        chk("fwd_valid", bus.valid_out, 1);
        chk("fwd_opr1", bus.opr1_out, 9);
        chk("fwd_opr2", bus.opr2_out, 32'h8000_0000);
        chk("fwd_dep", bus.dependency_out, 5);
        chk("fwd_op1", bus.alu_op_L1_out, 3);

        // Both buses carry the same tag: ALU value must win
        disp(3'd1, 1'b0, 32'd0, 5'd7, 32'd3, c_NO, 5'd9);
        bus.alu_cdb_ready_in = 1'b1;
        bus.alu_cdb_dep_in   = 5'd7;
        bus.alu_cdb_value_in = 32'h11;
        bus.lsb_cdb_ready_in = 1'b1;
        bus.lsb_cdb_dep_in   = 5'd7;
        bus.lsb_cdb_value_in = 32'h22;
        tick();
        idle();
        tick();
        chk("prio_valid", bus.valid_out, 1);
        chk("prio_opr1", bus.opr1_out, 32'h11);
        tick();

        // Fill all eight entries, each waiting on tag 1
        for (int i = 0; i < 8; i++) begin
            disp(3'd2, 1'b0, 32'd0, 5'd1, 32'd100 + 32'(i), c_NO, 5'(8 + i));
            tick();
        end
        idle();
        chk("fill_full", bus.full_out, 1);
        disp(3'd0, 1'b0, 32'd1, c_NO, 32'd2, c_NO, 5'd1);
        tick();
        idle();
        chk("full_no_issue", bus.valid_out, 0);
        chk("full_still", bus.full_out, 1);
        bus.alu_cdb_ready_in = 1'b1;
        bus.alu_cdb_dep_in   = 5'd1;
        bus.alu_cdb_value_in = 32'h55;
        tick();
        idle();
        chk("bcast_edge", bus.valid_out, 0);
        chk("bcast_full", bus.full_out, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_valid", bus.valid_out, 1);
            chk("drain_dep", bus.dependency_out, 64'(8 + i));
            chk("drain_opr1", bus.opr1_out, 32'h55);
            chk("drain_opr2", bus.opr2_out, 64'(100 + i));
            if (i == 0) chk("drain_full_drop", bus.full_out, 0);
        end
        tick();
        chk("drain_done", bus.valid_out, 0);

        // Flush with a ready entry present: nothing issues
        disp(3'd0, 1'b0, 32'd0, 5'd2, 32'd0, c_NO, 5'd10);
        tick();
        disp(3'd0, 1'b0, 32'd0, 5'd2, 32'd0, c_NO, 5'd11);
        tick();
        disp(3'd0, 1'b0, 32'h77, c_NO, 32'd0, c_NO, 5'd12);
        tick();
        idle();
        bus.need_flush_in = 1'b1;
        tick();
        idle();
        chk("flush_valid", bus.valid_out, 0);
        chk("flush_full", bus.full_out, 0);
        chk("flush_dep_hold", bus.dependency_out, 15);
        bus.alu_cdb_ready_in = 1'b1;
        bus.alu_cdb_dep_in   = 5'd2;
        bus.alu_cdb_value_in = 32'h99;
        tick();
        idle();
        tick();
        chk("flush_gone", bus.valid_out, 0);
        chk("flush_gone_dep", bus.dependency_out, 15);

        // rdy_in low freezes everything
        disp(3'd4, 1'b1, 32'hAA, c_NO, 32'hBB, c_NO, 5'd6);
        tick();
        idle();
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", bus.valid_out, 0);
            chk("hold_dep", bus.dependency_out, 15);
            chk("hold_opr1", bus.opr1_out, 32'h55);
        end
        bus.rdy_in = 1'b1;
        tick();
        chk("resume_valid", bus.valid_out, 1);
        chk("resume_dep", bus.dependency_out, 6);
        chk("resume_opr1", bus.opr1_out, 32'hAA);
        chk("resume_op1", bus.alu_op_L1_out, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
